// File: rtl/led_ctl_multi_if.sv
// Run-time configuration port of led_ctl_multi.
// The master issues a one-cycle write strobe; the slave answers with a one-cycle ack or err pulse.
interface led_ctl_multi_if #(
    parameter int unsigned CHW = 2
);
    logic           cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [1:0]     cfg_mode;
    logic [15:0]    cfg_period;
    logic           cfg_ack;
    logic           cfg_err;

    modport master (
        output cfg_we, cfg_ch, cfg_mode, cfg_period,
        input  cfg_ack, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_mode, cfg_period,
        output cfg_ack, cfg_err
    );
endinterface

// File: rtl/led_ctl_multi.sv
// Multi-channel LED driver: per-channel off/on/blink/breathe with run-time configuration.
// A shared prescaler generates the tick time base; a shared PWM counter shapes breathe mode.
module led_ctl_multi #(
    parameter int unsigned CH         = 4,
    parameter int unsigned CLK_HZ     = 25000000,
    parameter int unsigned TICK_HZ    = 1000,
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned RST_MODE   = 2,
    parameter int unsigned RST_PERIOD = 500,
    parameter bit          ACTIVE_LOW = 1'b0,
    localparam int unsigned CHW       = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    led_ctl_multi_if.slave  cfg,
    output logic            tick,
    output logic [CH-1:0]   led
);

    localparam int unsigned DIV_RAW = CLK_HZ / TICK_HZ;
    localparam int unsigned DIV     = (DIV_RAW > 0) ? DIV_RAW : 1;
    localparam int unsigned PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] DUTY_ONE = PWM_BITS'(1);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    // Last count value of a period; a stored period of 0 behaves as 1.
    function automatic logic [15:0] last_cnt(input logic [15:0] per);
        return (per == 16'd0) ? 16'd0 : per - 16'd1;
    endfunction

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic                tick_q, tick_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic [CH-1:0]       led_q, led_d;

    mode_e               mode_q   [CH];
    mode_e               mode_d   [CH];
    logic [15:0]         period_q [CH];
    logic [15:0]         period_d [CH];
    logic [15:0]         cnt_q    [CH];
    logic [15:0]         cnt_d    [CH];
    logic [PWM_BITS-1:0] duty_q   [CH];
    logic [PWM_BITS-1:0] duty_d   [CH];
    logic [CH-1:0]       phase_q, phase_d;
    logic [CH-1:0]       dir_q, dir_d;

    logic [CHW-1:0]      ch_sel;
    logic                in_range;
    logic [CH-1:0]       lit;

    assign ch_sel   = cfg.cfg_ch;
    assign in_range = (32'(ch_sel) < CH);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q   <= '0;
            pwm_q   <= '0;
            tick_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            led_q   <= {CH{ACTIVE_LOW}};
            phase_q <= '0;
            dir_q   <= '0;
            for (int i = 0; i < CH; i++) begin
                mode_q[i]   <= mode_e'(2'(RST_MODE));
                period_q[i] <= 16'(RST_PERIOD);
                cnt_q[i]    <= '0;
                duty_q[i]   <= '0;
            end
        end else begin
            pre_q   <= pre_d;
            pwm_q   <= pwm_d;
            tick_q  <= tick_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            led_q   <= led_d;
            phase_q <= phase_d;
            dir_q   <= dir_d;
            for (int i = 0; i < CH; i++) begin
                mode_q[i]   <= mode_d[i];
                period_q[i] <= period_d[i];
                cnt_q[i]    <= cnt_d[i];
                duty_q[i]   <= duty_d[i];
            end
        end
    end

    // Per-channel lit level from the registered channel state.
    always_comb begin
        lit = '0;
        for (int i = 0; i < CH; i++) begin
            case (mode_q[i])
                MODE_ON:      lit[i] = 1'b1;
                MODE_BLINK:   lit[i] = phase_q[i];
                MODE_BREATHE: lit[i] = (pwm_q < duty_q[i]);
                default:      lit[i] = 1'b0;
            endcase
        end
    end

    // Next-state: time base, channel sequencing, then config write overriding its channel.
    always_comb begin
        pre_d   = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
        tick_d  = (pre_q == PRE_LAST);
        pwm_d   = pwm_q + DUTY_ONE;
        ack_d   = cfg.cfg_we &&  in_range;
        err_d   = cfg.cfg_we && !in_range;
        led_d   = lit ^ {CH{ACTIVE_LOW}};
        phase_d = phase_q;
        dir_d   = dir_q;
        for (int i = 0; i < CH; i++) begin
            mode_d[i]   = mode_q[i];
            period_d[i] = period_q[i];
            cnt_d[i]    = cnt_q[i];
            duty_d[i]   = duty_q[i];

            if (tick_q) begin
                case (mode_q[i])
                    MODE_BLINK: begin
                        if (cnt_q[i] == last_cnt(period_q[i])) begin
                            cnt_d[i]   = '0;
                            phase_d[i] = ~phase_q[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + 16'd1;
                        end
                    end
                    MODE_BREATHE: begin
                        if (cnt_q[i] == last_cnt(period_q[i])) begin
                            cnt_d[i] = '0;
                            // dir 0 ramps up, 1 ramps down; it turns at either end of the range
                            if (!dir_q[i]) begin
                                duty_d[i] = duty_q[i] + DUTY_ONE;
                                if (duty_d[i] == DUTY_MAX) begin
                                    dir_d[i] = 1'b1;
                                end
                            end else begin
                                duty_d[i] = duty_q[i] - DUTY_ONE;
                                if (duty_d[i] == '0) begin
                                    dir_d[i] = 1'b0;
                                end
                            end
                        end else begin
                            cnt_d[i] = cnt_q[i] + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end

            if (cfg.cfg_we && in_range && (ch_sel == CHW'(i))) begin
                mode_d[i]   = mode_e'(cfg.cfg_mode);
                period_d[i] = cfg.cfg_period;
                cnt_d[i]    = '0;
                duty_d[i]   = '0;
                phase_d[i]  = 1'b0;
                dir_d[i]    = 1'b0;
            end
        end
    end

    assign tick        = tick_q;
    assign led         = led_q;
    assign cfg.cfg_ack = ack_q;
    assign cfg.cfg_err = err_q;

endmodule

// File: tb/tb_led_ctl_multi.sv
// Directed bench for led_ctl_multi: three instances (active-high CH=4, active-low CH=4, CH=5 range check).
module tb_led_ctl_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  led, led2;
    logic [4:0]  led3;
    logic        tick, tick2, tick3;
    int unsigned cyc = 0;
    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    led_ctl_multi_if #(.CHW(2)) cfg_a ();
    led_ctl_multi_if #(.CHW(2)) cfg_b ();
    led_ctl_multi_if #(.CHW(3)) cfg_c ();

    led_ctl_multi #(
        .CH(4), .CLK_HZ(1000), .TICK_HZ(100), .PWM_BITS(4),
        .RST_MODE(2), .RST_PERIOD(3), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .cfg(cfg_a), .tick(tick), .led(led)
    );

    led_ctl_multi #(
        .CH(4), .CLK_HZ(1000), .TICK_HZ(100), .PWM_BITS(4),
        .RST_MODE(2), .RST_PERIOD(3), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .rst(rst), .cfg(cfg_b), .tick(tick2), .led(led2)
    );

    led_ctl_multi #(
        .CH(5), .CLK_HZ(1000), .TICK_HZ(100), .PWM_BITS(4),
        .RST_MODE(1), .RST_PERIOD(3), .ACTIVE_LOW(1'b0)
    ) dut_c5 (
        .clk(clk), .rst(rst), .cfg(cfg_c), .tick(tick3), .led(led3)
    );

    always #5 clk = ~clk;

    // Edges since reset release; after edge n the counter reads n.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic goto(input int unsigned n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input int sel, input logic [2:0] ch, input logic [1:0] mode,
                             input logic [15:0] per);
        case (sel)
            1: begin cfg_a.cfg_we = 1'b1; cfg_a.cfg_ch = ch[1:0];
                     cfg_a.cfg_mode = mode; cfg_a.cfg_period = per; end
            2: begin cfg_b.cfg_we = 1'b1; cfg_b.cfg_ch = ch[1:0];
                     cfg_b.cfg_mode = mode; cfg_b.cfg_period = per; end
            default: begin cfg_c.cfg_we = 1'b1; cfg_c.cfg_ch = ch;
                     cfg_c.cfg_mode = mode; cfg_c.cfg_period = per; end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_release();
        cfg_a.cfg_we = 1'b0;
        cfg_b.cfg_we = 1'b0;
        cfg_c.cfg_we = 1'b0;
    endtask

    function automatic int unsigned breathe_duty(input int unsigned k);
        int unsigned m;
        m = k % 30;
        return (m <= 15) ? m : 30 - m;
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        logic exp_lit;
        cfg_release();
        cfg_a.cfg_ch = '0; cfg_a.cfg_mode = '0; cfg_a.cfg_period = '0;
        cfg_b.cfg_ch = '0; cfg_b.cfg_mode = '0; cfg_b.cfg_period = '0;
        cfg_c.cfg_ch = '0; cfg_c.cfg_mode = '0; cfg_c.cfg_period = '0;

        // Reset state
        @(posedge clk); #1;
        check_val("rst_led",   32'(led),   32'h0);
        check_val("rst_led_al", 32'(led2), 32'hF);
        check_val("rst_tick",  32'(tick),  32'h0);
        check_val("rst_ack",   32'(cfg_a.cfg_ack), 32'h0);
        check_val("rst_err",   32'(cfg_a.cfg_err), 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // CH=5 instance: lit on reset, channel 4 valid, 5 and 7 rejected, back-to-back writes
        goto(1);
        check_val("c5_on",     32'(led3), 32'h1F);
        goto(2);
        cfg_write(3, 3'd4, 2'd0, 16'd3);
        check_val("c5_ack4",   32'(cfg_c.cfg_ack), 32'h1);
        check_val("c5_noerr4", 32'(cfg_c.cfg_err), 32'h0);
        check_val("c5_led_lag", 32'(led3), 32'h1F);
        cfg_release();
        goto(4);
        check_val("c5_led4",   32'(led3), 32'h0F);
        cfg_write(3, 3'd5, 2'd0, 16'd3);
        check_val("c5_err5",   32'(cfg_c.cfg_err), 32'h1);
        check_val("c5_noack5", 32'(cfg_c.cfg_ack), 32'h0);
        cfg_release();
        goto(6);
        check_val("c5_err_pulse", 32'(cfg_c.cfg_err), 32'h0);
        check_val("c5_led_kept",  32'(led3), 32'h0F);
        cfg_write(3, 3'd7, 2'd0, 16'd3);
        check_val("c5_err7",   32'(cfg_c.cfg_err), 32'h1);
        cfg_write(3, 3'd0, 2'd0, 16'd3);
        check_val("c5_b2b0_ack", 32'(cfg_c.cfg_ack), 32'h1);
        check_val("c5_b2b0_err", 32'(cfg_c.cfg_err), 32'h0);
        cfg_write(3, 3'd1, 2'd0, 16'd3);
        check_val("c5_b2b1_ack", 32'(cfg_c.cfg_ack), 32'h1);
        cfg_release();

        // Tick every 10 clk; blink P=3 toggles every 30 clk in lockstep
        check_val("tick_9",    32'(tick),  32'h0);
        goto(10);
        check_val("tick_10",   32'(tick),  32'h1);
        check_val("tick_al_10", 32'(tick2), 32'h1);
        check_val("tick_c5_10", 32'(tick3), 32'h1);
        check_val("c5_b2b_led", 32'(led3), 32'h0C);
        check_val("c5_ack_pulse", 32'(cfg_c.cfg_ack), 32'h0);
        goto(11);
        check_val("tick_11",   32'(tick),  32'h0);
        goto(20);
        check_val("tick_20",   32'(tick),  32'h1);
        goto(31);
        check_val("blink_31",  32'(led),   32'h0);
        goto(32);
        check_val("blink_32",  32'(led),   32'hF);
        check_val("blink_al_32", 32'(led2), 32'h0);
        goto(61);
        check_val("blink_61",  32'(led),   32'hF);
        goto(62);
        check_val("blink_62",  32'(led),   32'h0);

        // ch1 -> on: ack next cycle, led two cycles after the write
        cfg_write(1, 3'd1, 2'd1, 16'd3);
        check_val("on_ack",    32'(cfg_a.cfg_ack), 32'h1);
        check_val("on_lag",    32'(led),   32'h0);
        cfg_release();
        goto(64);
        check_val("on_ack_pulse", 32'(cfg_a.cfg_ack), 32'h0);
        check_val("on_led",    32'(led),   32'h2);
        goto(92);
        check_val("on_others", 32'(led),   32'hF);

        // ch2 -> blink with period 0 (acts as 1): toggles every tick
        cfg_write(1, 3'd2, 2'd2, 16'd0);
        cfg_release();
        goto(94);
        check_val("p0_clear",  32'(led),   32'hB);
        goto(101);
        check_val("p0_101",    32'(led),   32'hB);
        goto(102);
        check_val("p0_102",    32'(led),   32'hF);
        goto(111);
        check_val("p0_111",    32'(led),   32'hF);
        goto(112);
        check_val("p0_112",    32'(led),   32'hB);

        // ch3 -> breathe, one tick per duty step; duty 0..15..0 against pwm = edge mod 16
        cfg_write(1, 3'd3, 2'd3, 16'd1);
        check_val("br_ack",    32'(cfg_a.cfg_ack), 32'h1);
        cfg_release();
        for (int unsigned n = 114; n < 434; n++) begin
            goto(n);
            exp_lit = ((n - 1) % 16) < breathe_duty((n - 1 - 111) / 10);
            check_val("breathe", 32'(led[3]), 32'(exp_lit));
        end

        // ch0 written on a tick edge restarts; ch2 still advances on that tick
        goto(440);
        check_val("tw_tick",   32'(tick),  32'h1);
        cfg_write(1, 3'd0, 2'd2, 16'd3);
        check_val("tw_ack",    32'(cfg_a.cfg_ack), 32'h1);
        cfg_release();
        goto(442);
        check_val("tw_ch0_442", 32'(led[0]), 32'h0);
        check_val("tw_ch2_442", 32'(led[2]), 32'h1);
        goto(452);
        check_val("tw_ch0_452", 32'(led[0]), 32'h0);
        check_val("tw_ch2_452", 32'(led[2]), 32'h0);
        check_val("tw_ch1_452", 32'(led[1]), 32'h1);
        goto(471);
        check_val("tw_ch0_471", 32'(led[0]), 32'h0);
        goto(472);
        check_val("tw_ch0_472", 32'(led[0]), 32'h1);

        // Reset mid-breathe clears everything, including a pending tick
        goto(480);
        check_val("mr_tick_pre", 32'(tick), 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("mr_led",    32'(led),   32'h0);
        check_val("mr_tick",   32'(tick),  32'h0);
        check_val("mr_led_al", 32'(led2),  32'hF);
        check_val("mr_ack",    32'(cfg_a.cfg_ack), 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        goto(10);
        check_val("mr_tick_10", 32'(tick), 32'h1);
        goto(31);
        check_val("mr_blink_31", 32'(led),  32'h0);
        check_val("mr_al_31",    32'(led2), 32'hF);
        goto(32);
        check_val("mr_blink_32", 32'(led),  32'hF);
        check_val("mr_al_32",    32'(led2), 32'h0);

        // Active-low instance: ch1 -> off drives its pin high
        goto(40);
        cfg_write(2, 3'd1, 2'd0, 16'd3);
        check_val("al_ack",    32'(cfg_b.cfg_ack), 32'h1);
        cfg_release();
        goto(42);
        check_val("al_off",    32'(led2),  32'h2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
